// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Request/grant/acknowledge bundle between the data-memory
//                port arbiter and its requesters / memory interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic [3:0] req;        // level-held request per requester
    logic       mem_ready;  // memory completes the current transaction
    logic [3:0] grant;      // one-hot registered grant
    logic [1:0] sel;        // port-mux select (index of granted requester)
    logic       mem_valid;  // transaction presented to memory
    logic [3:0] ack;        // one-cycle completion pulse
    logic       timeout;    // one-cycle abort pulse

    // Arbiter side: owns grant/select/handshake outputs.
    modport master (
        input  req,
        input  mem_ready,
        output grant,
        output sel,
        output mem_valid,
        output ack,
        output timeout
    );

    // Environment side: requesters plus memory.
    modport slave (
        output req,
        output mem_ready,
        input  grant,
        input  sel,
        input  mem_valid,
        input  ack,
        input  timeout
    );
endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter for the shared 32-bit data-memory port.
//                Four requesters (fetch, LSU, debug, DMA); one transaction at
//                a time, back-to-back grants on completion, registered
//                one-cycle ack. Optional transaction watchdog enabled by
//                defining the macro ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mem_port_arbiter_if.master    bus
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
            $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 2..256");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state,   w_state_nxt;
    logic [3:0] r_grant,   w_grant_nxt;
    logic [1:0] r_sel,     w_sel_nxt;
    logic [1:0] r_ptr,     w_ptr_nxt;
    logic [3:0] r_ack,     w_ack_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       w_load;

    logic [3:0] w_search_req;
    logic [1:0] w_search_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_done;
    logic       w_abort;

    assign w_done = (r_state == S_BUSY) && bus.mem_ready;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;

    // Abort only when the stall budget is used up; a ready on the same edge wins.
    assign w_abort = (r_state == S_BUSY) && !bus.mem_ready && (r_cnt == c_TMO_LAST);

    // Stall counter: restarts with every new grant, counts non-ready BUSY cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (w_load) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_BUSY) && !bus.mem_ready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Winner search: first set bit of the eligible requests starting at the
    // priority pointer. While BUSY the pointer used is the one that will take
    // effect at this edge (sel+1) and the current owner is masked out.
    always_comb begin
        w_search_req = (r_state == S_BUSY) ? (bus.req & ~r_grant) : bus.req;
        w_search_ptr = (r_state == S_BUSY) ? (r_sel + 2'd1) : r_ptr;
        w_found      = 1'b0;
        w_win        = 2'd0;
        w_idx        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = w_search_ptr + 2'(k);
            if (!w_found && w_search_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-output logic; every register holds unless told otherwise.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_sel_nxt     = r_sel;
        w_ptr_nxt     = r_ptr;
        w_ack_nxt     = 4'b0000;
        w_timeout_nxt = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_load      = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_done || w_abort) begin
                    w_ptr_nxt     = r_sel + 2'd1;
                    w_ack_nxt     = w_done ? r_grant : 4'b0000;
                    w_timeout_nxt = w_abort;
                    if (w_found) begin
                        w_grant_nxt = 4'b0001 << w_win;
                        w_sel_nxt   = w_win;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= 4'b0000;
            r_sel     <= 2'd0;
            r_ptr     <= 2'd0;
            r_ack     <= 4'b0000;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_ptr     <= w_ptr_nxt;
            r_ack     <= w_ack_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.mem_valid = |r_grant;
    assign bus.ack       = r_ack;
    assign bus.timeout   = r_timeout;

endmodule : mem_port_arbiter
`default_nettype wire
